hazard_scoreboard: RTL

Parametrised next-generation hazard unit for the 5-stage pipelined RISC-V core (F/D/E/M/W). It keeps the existing hazard handling: M/W-to-E forwarding, load-use stall and taken-branch/jump flush. It adds support for a multi-cycle execute unit (MUL/DIV) that holds the E stage for MC_LAT cycles, tracked by an internal down-counter, and adds a stallE / flushM pair to the datapath.

---
 rtl/hazard_scoreboard.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit: M/W-to-E forwarding, load-use stall, branch flush and multi-cycle E-stage hold.
// Latency: all stall/flush/forward outputs are combinational; only the multi-cycle counter is registered.
// Backpressure: a multi-cycle op freezes F/D/E and bubbles M until its last cycle. Optional counters: HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int MC_LAT = 4,   // legal range 2..15
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              regwrM,
    input  logic              regwrW,
    input  logic              resultsrcE0,
    input  logic              PCsrcE0,
    input  logic              mc_startE,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              mc_doneE
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_lw_stalls,
    output logic [CNT_W-1:0]  perf_mc_stalls,
    output logic [CNT_W-1:0]  perf_flushes
`endif
);

    // Counter reload value: the first cycle of the op is the load cycle itself.
    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);

    logic [3:0] mc_cnt_q, mc_cnt_d;
    logic       lwstall;
    logic       mcstall;
    logic       lw_eff;
    logic       br_eff;

    // Forwarding select per operand; M beats W, x0 never forwards.
    always_comb begin
        forwardAE = 2'b00;
        forwardBE = 2'b00;
        if (!rst) begin
            if (regwrM && (rdM != '0) && (rdM == rs1E))      forwardAE = 2'b10;
            else if (regwrW && (rdW != '0) && (rdW == rs1E)) forwardAE = 2'b01;
            if (regwrM && (rdM != '0) && (rdM == rs2E))      forwardBE = 2'b10;
            else if (regwrW && (rdW != '0) && (rdW == rs2E)) forwardBE = 2'b01;
        end
    end

    // Multi-cycle counter next state; mc_startE is ignored on the final (count 1) cycle.
    always_comb begin
        mc_cnt_d = 4'd0;
        if ((mc_cnt_q == 4'd0) && mc_startE) mc_cnt_d = MC_LOAD;
        else if (mc_cnt_q != 4'd0)           mc_cnt_d = mc_cnt_q - 4'd1;
    end

    // Multi-cycle counter register; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (rst) mc_cnt_q <= 4'd0;
        else     mc_cnt_q <= mc_cnt_d;
    end

    // Prioritised stall/flush: multi-cycle hold, then branch flush, then load-use.
    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushM   = 1'b0;
        mc_doneE = 1'b0;
        lwstall  = resultsrcE0 && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
        mcstall  = ((mc_cnt_q == 4'd0) && mc_startE) || (mc_cnt_q > 4'd1);
        lw_eff   = 1'b0;
        br_eff   = 1'b0;
        if (!rst) begin
            mc_doneE = (mc_cnt_q == 4'd1);
            if (mcstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
            end else if (PCsrcE0) begin
                flushD = 1'b1;
                flushE = 1'b1;
                br_eff = 1'b1;
            end else if (lwstall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                flushE = 1'b1;
                lw_eff = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] perf_lw_q, perf_mc_q, perf_fl_q;
    logic             mc_eff;

    assign mc_eff = mcstall && !rst;

    // Saturating event counters, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lw_q <= '0;
            perf_mc_q <= '0;
            perf_fl_q <= '0;
        end else begin
            if (lw_eff && !(&perf_lw_q)) perf_lw_q <= perf_lw_q + 1'b1;
            if (mc_eff && !(&perf_mc_q)) perf_mc_q <= perf_mc_q + 1'b1;
            if (br_eff && !(&perf_fl_q)) perf_fl_q <= perf_fl_q + 1'b1;
        end
    end

    assign perf_lw_stalls = perf_lw_q;
    assign perf_mc_stalls = perf_mc_q;
    assign perf_flushes   = perf_fl_q;
`else
    // Without the counters the width parameter has no effect.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
    logic unused_eff;
    assign unused_eff = lw_eff ^ br_eff;
`endif

endmodule
